// File: rtl/axi_lite_ram_arbiter_2to1.sv
// Two-master to one-slave AXI-Lite arbiter for the shared on-chip RAM.
// Read and write paths are arbitrated independently with round-robin grant.
module axi_lite_ram_arbiter_2to1 #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                    ACLK,
  input  logic                    ARESET,
  input  logic [ADDR_WIDTH-1:0]   S0_AXI_awaddr,
  input  logic [2:0]              S0_AXI_awprot,
  input  logic                    S0_AXI_awvalid,
  output logic                    S0_AXI_awready,
  input  logic [DATA_WIDTH-1:0]   S0_AXI_wdata,
  input  logic [DATA_WIDTH/8-1:0] S0_AXI_wstrb,
  input  logic                    S0_AXI_wvalid,
  output logic                    S0_AXI_wready,
  output logic [1:0]              S0_AXI_bresp,
  output logic                    S0_AXI_bvalid,
  input  logic                    S0_AXI_bready,
  input  logic [ADDR_WIDTH-1:0]   S0_AXI_araddr,
  input  logic [2:0]              S0_AXI_arprot,
  input  logic                    S0_AXI_arvalid,
  output logic                    S0_AXI_arready,
  output logic [DATA_WIDTH-1:0]   S0_AXI_rdata,
  output logic [1:0]              S0_AXI_rresp,
  output logic                    S0_AXI_rvalid,
  input  logic                    S0_AXI_rready,
  input  logic [ADDR_WIDTH-1:0]   S1_AXI_awaddr,
  input  logic [2:0]              S1_AXI_awprot,
  input  logic                    S1_AXI_awvalid,
  output logic                    S1_AXI_awready,
  input  logic [DATA_WIDTH-1:0]   S1_AXI_wdata,
  input  logic [DATA_WIDTH/8-1:0] S1_AXI_wstrb,
  input  logic                    S1_AXI_wvalid,
  output logic                    S1_AXI_wready,
  output logic [1:0]              S1_AXI_bresp,
  output logic                    S1_AXI_bvalid,
  input  logic                    S1_AXI_bready,
  input  logic [ADDR_WIDTH-1:0]   S1_AXI_araddr,
  input  logic [2:0]              S1_AXI_arprot,
  input  logic                    S1_AXI_arvalid,
  output logic                    S1_AXI_arready,
  output logic [DATA_WIDTH-1:0]   S1_AXI_rdata,
  output logic [1:0]              S1_AXI_rresp,
  output logic                    S1_AXI_rvalid,
  input  logic                    S1_AXI_rready,
  output logic [ADDR_WIDTH-1:0]   M_AXI_awaddr,
  output logic [2:0]              M_AXI_awprot,
  output logic                    M_AXI_awvalid,
  input  logic                    M_AXI_awready,
  output logic [DATA_WIDTH-1:0]   M_AXI_wdata,
  output logic [DATA_WIDTH/8-1:0] M_AXI_wstrb,
  output logic                    M_AXI_wvalid,
  input  logic                    M_AXI_wready,
  input  logic [1:0]              M_AXI_bresp,
  input  logic                    M_AXI_bvalid,
  output logic                    M_AXI_bready,
  output logic [ADDR_WIDTH-1:0]   M_AXI_araddr,
  output logic [2:0]              M_AXI_arprot,
  output logic                    M_AXI_arvalid,
  input  logic                    M_AXI_arready,
  input  logic [DATA_WIDTH-1:0]   M_AXI_rdata,
  input  logic [1:0]              M_AXI_rresp,
  input  logic                    M_AXI_rvalid,
  output logic                    M_AXI_rready,
  output logic [1:0]              wr_grant,
  output logic [1:0]              rd_grant
);

  typedef enum logic [1:0] {W_IDLE, W_FWD, W_RESP} wst_e;
  typedef enum logic [1:0] {R_IDLE, R_ADDR, R_DATA} rst_e;

  wst_e wst_q, wst_d;
  rst_e rst_q, rst_d;
  logic wsel_q, wsel_d, wlast_q, wlast_d;
  logic rsel_q, rsel_d, rlast_q, rlast_d;
  logic aw_done_q, aw_done_d, w_done_q, w_done_d;
  logic [1:0] wreq, rreq, awrdy, wrdy, bvld, arrdy, rvld;

  // Last winner gets lower priority on a tie; a lone requester always wins.
  function automatic logic pick(input logic [1:0] req, input logic last);
    return (req == 2'b11) ? ~last : req[1];
  endfunction

  assign wreq = {S1_AXI_awvalid & S1_AXI_wvalid, S0_AXI_awvalid & S0_AXI_wvalid};
  assign rreq = {S1_AXI_arvalid, S0_AXI_arvalid};

  always_comb begin
    wst_d = wst_q;  wsel_d = wsel_q;  wlast_d = wlast_q;
    aw_done_d = aw_done_q;  w_done_d = w_done_q;
    M_AXI_awaddr = '0;  M_AXI_awprot = '0;  M_AXI_awvalid = 1'b0;
    M_AXI_wdata  = '0;  M_AXI_wstrb  = '0;  M_AXI_wvalid  = 1'b0;
    M_AXI_bready = 1'b0;
    awrdy = '0;  wrdy = '0;  bvld = '0;
    S0_AXI_bresp = '0;  S1_AXI_bresp = '0;
    unique case (wst_q)
      W_IDLE: if (|wreq) begin
        wsel_d = pick(wreq, wlast_q);
        aw_done_d = 1'b0;
        w_done_d = 1'b0;
        wst_d = W_FWD;
      end
      W_FWD: begin
        M_AXI_awaddr  = wsel_q ? S1_AXI_awaddr : S0_AXI_awaddr;
        M_AXI_awprot  = wsel_q ? S1_AXI_awprot : S0_AXI_awprot;
        M_AXI_wdata   = wsel_q ? S1_AXI_wdata  : S0_AXI_wdata;
        M_AXI_wstrb   = wsel_q ? S1_AXI_wstrb  : S0_AXI_wstrb;
        M_AXI_awvalid = (wsel_q ? S1_AXI_awvalid : S0_AXI_awvalid) & ~aw_done_q;
        M_AXI_wvalid  = (wsel_q ? S1_AXI_wvalid  : S0_AXI_wvalid)  & ~w_done_q;
        awrdy[wsel_q] = M_AXI_awready & ~aw_done_q;
        wrdy[wsel_q]  = M_AXI_wready & ~w_done_q;
        aw_done_d = aw_done_q | (M_AXI_awvalid & M_AXI_awready);
        w_done_d  = w_done_q  | (M_AXI_wvalid  & M_AXI_wready);
        if (aw_done_d && w_done_d) wst_d = W_RESP;
      end
      W_RESP: begin
        bvld[wsel_q] = M_AXI_bvalid;
        if (wsel_q) S1_AXI_bresp = M_AXI_bresp;
        else        S0_AXI_bresp = M_AXI_bresp;
        M_AXI_bready = wsel_q ? S1_AXI_bready : S0_AXI_bready;
        if (M_AXI_bvalid && M_AXI_bready) begin
          wst_d = W_IDLE;
          wlast_d = wsel_q;
        end
      end
      default: wst_d = W_IDLE;
    endcase
  end

  always_comb begin
    rst_d = rst_q;  rsel_d = rsel_q;  rlast_d = rlast_q;
    M_AXI_araddr = '0;  M_AXI_arprot = '0;  M_AXI_arvalid = 1'b0;
    M_AXI_rready = 1'b0;
    arrdy = '0;  rvld = '0;
    S0_AXI_rdata = '0;  S0_AXI_rresp = '0;
    S1_AXI_rdata = '0;  S1_AXI_rresp = '0;
    unique case (rst_q)
      R_IDLE: if (|rreq) begin
        rsel_d = pick(rreq, rlast_q);
        rst_d = R_ADDR;
      end
      R_ADDR: begin
        M_AXI_araddr  = rsel_q ? S1_AXI_araddr  : S0_AXI_araddr;
        M_AXI_arprot  = rsel_q ? S1_AXI_arprot  : S0_AXI_arprot;
        M_AXI_arvalid = rsel_q ? S1_AXI_arvalid : S0_AXI_arvalid;
        arrdy[rsel_q] = M_AXI_arready;
        if (M_AXI_arvalid && M_AXI_arready) rst_d = R_DATA;
      end
      R_DATA: begin
        rvld[rsel_q] = M_AXI_rvalid;
        if (rsel_q) begin
          S1_AXI_rdata = M_AXI_rdata;
          S1_AXI_rresp = M_AXI_rresp;
        end else begin
          S0_AXI_rdata = M_AXI_rdata;
          S0_AXI_rresp = M_AXI_rresp;
        end
        M_AXI_rready = rsel_q ? S1_AXI_rready : S0_AXI_rready;
        if (M_AXI_rvalid && M_AXI_rready) begin
          rst_d = R_IDLE;
          rlast_d = rsel_q;
        end
      end
      default: rst_d = R_IDLE;
    endcase
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      wst_q <= W_IDLE;  wsel_q <= 1'b0;  wlast_q <= 1'b1;
      aw_done_q <= 1'b0;  w_done_q <= 1'b0;
      rst_q <= R_IDLE;  rsel_q <= 1'b0;  rlast_q <= 1'b1;
    end else begin
      wst_q <= wst_d;  wsel_q <= wsel_d;  wlast_q <= wlast_d;
      aw_done_q <= aw_done_d;  w_done_q <= w_done_d;
      rst_q <= rst_d;  rsel_q <= rsel_d;  rlast_q <= rlast_d;
    end
  end

  assign {S1_AXI_awready, S0_AXI_awready} = awrdy;
  assign {S1_AXI_wready,  S0_AXI_wready}  = wrdy;
  assign {S1_AXI_bvalid,  S0_AXI_bvalid}  = bvld;
  assign {S1_AXI_arready, S0_AXI_arready} = arrdy;
  assign {S1_AXI_rvalid,  S0_AXI_rvalid}  = rvld;
  assign wr_grant = (wst_q == W_IDLE) ? 2'b00 : {wsel_q, ~wsel_q};
  assign rd_grant = (rst_q == R_IDLE) ? 2'b00 : {rsel_q, ~rsel_q};

endmodule

// File: tb/tb_axi_lite_ram_arbiter_2to1.sv
// Directed bench for the 2:1 AXI-Lite arbiter: two bench masters, a RAM slave
// model on the M side, and per-master scoreboards of expected responses.
module tb_axi_lite_ram_arbiter_2to1;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [31:0] s_awaddr[2], s_wdata[2], s_araddr[2], s_rdata[2];
  logic [2:0]  s_awprot[2], s_arprot[2];
  logic [3:0]  s_wstrb[2];
  logic s_awvalid[2], s_wvalid[2], s_bready[2], s_arvalid[2], s_rready[2];
  logic s_awready[2], s_wready[2], s_bvalid[2], s_arready[2], s_rvalid[2];
  logic [1:0] s_bresp[2], s_rresp[2];

  logic [31:0] M_awaddr, M_wdata, M_araddr, M_rdata;
  logic [2:0]  M_awprot, M_arprot;
  logic [3:0]  M_wstrb;
  logic M_awvalid, M_awready, M_wvalid, M_wready, M_bvalid, M_bready;
  logic M_arvalid, M_arready, M_rvalid, M_rready;
  logic [1:0] M_bresp, M_rresp, wr_grant, rd_grant;

  axi_lite_ram_arbiter_2to1 #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
    .ACLK(clk), .ARESET(rst),
    .S0_AXI_awaddr(s_awaddr[0]), .S0_AXI_awprot(s_awprot[0]), .S0_AXI_awvalid(s_awvalid[0]),
    .S0_AXI_awready(s_awready[0]), .S0_AXI_wdata(s_wdata[0]), .S0_AXI_wstrb(s_wstrb[0]),
    .S0_AXI_wvalid(s_wvalid[0]), .S0_AXI_wready(s_wready[0]), .S0_AXI_bresp(s_bresp[0]),
    .S0_AXI_bvalid(s_bvalid[0]), .S0_AXI_bready(s_bready[0]), .S0_AXI_araddr(s_araddr[0]),
    .S0_AXI_arprot(s_arprot[0]), .S0_AXI_arvalid(s_arvalid[0]), .S0_AXI_arready(s_arready[0]),
    .S0_AXI_rdata(s_rdata[0]), .S0_AXI_rresp(s_rresp[0]), .S0_AXI_rvalid(s_rvalid[0]),
    .S0_AXI_rready(s_rready[0]),
    .S1_AXI_awaddr(s_awaddr[1]), .S1_AXI_awprot(s_awprot[1]), .S1_AXI_awvalid(s_awvalid[1]),
    .S1_AXI_awready(s_awready[1]), .S1_AXI_wdata(s_wdata[1]), .S1_AXI_wstrb(s_wstrb[1]),
    .S1_AXI_wvalid(s_wvalid[1]), .S1_AXI_wready(s_wready[1]), .S1_AXI_bresp(s_bresp[1]),
    .S1_AXI_bvalid(s_bvalid[1]), .S1_AXI_bready(s_bready[1]), .S1_AXI_araddr(s_araddr[1]),
    .S1_AXI_arprot(s_arprot[1]), .S1_AXI_arvalid(s_arvalid[1]), .S1_AXI_arready(s_arready[1]),
    .S1_AXI_rdata(s_rdata[1]), .S1_AXI_rresp(s_rresp[1]), .S1_AXI_rvalid(s_rvalid[1]),
    .S1_AXI_rready(s_rready[1]),
    .M_AXI_awaddr(M_awaddr), .M_AXI_awprot(M_awprot), .M_AXI_awvalid(M_awvalid),
    .M_AXI_awready(M_awready), .M_AXI_wdata(M_wdata), .M_AXI_wstrb(M_wstrb),
    .M_AXI_wvalid(M_wvalid), .M_AXI_wready(M_wready), .M_AXI_bresp(M_bresp),
    .M_AXI_bvalid(M_bvalid), .M_AXI_bready(M_bready), .M_AXI_araddr(M_araddr),
    .M_AXI_arprot(M_arprot), .M_AXI_arvalid(M_arvalid), .M_AXI_arready(M_arready),
    .M_AXI_rdata(M_rdata), .M_AXI_rresp(M_rresp), .M_AXI_rvalid(M_rvalid),
    .M_AXI_rready(M_rready),
    .wr_grant(wr_grant), .rd_grant(rd_grant)
  );

  // RAM slave model: address 0xF0 answers SLVERR so error forwarding is visible.
  logic [31:0] smem [256];
  logic aw_p, w_p;
  logic [31:0] sa_addr, sw_data;
  logic [3:0] sw_strb;
  assign M_awready = !aw_p;
  assign M_wready  = !w_p;
  assign M_arready = !M_rvalid;

  always @(posedge clk) begin
    if (rst) begin
      aw_p <= 1'b0;  w_p <= 1'b0;
      M_bvalid <= 1'b0;  M_bresp <= 2'b00;
      M_rvalid <= 1'b0;  M_rdata <= '0;  M_rresp <= 2'b00;
      sa_addr <= '0;  sw_data <= '0;  sw_strb <= '0;
      for (int i = 0; i < 256; i++) smem[i] <= '0;
    end else begin
      if (M_awvalid && M_awready) begin aw_p <= 1'b1; sa_addr <= M_awaddr; end
      if (M_wvalid && M_wready) begin w_p <= 1'b1; sw_data <= M_wdata; sw_strb <= M_wstrb; end
      if (aw_p && w_p && !M_bvalid) begin
        for (int b = 0; b < 4; b++)
          if (sw_strb[b]) smem[sa_addr[9:2]][8*b +: 8] <= sw_data[8*b +: 8];
        M_bvalid <= 1'b1;
        M_bresp <= (sa_addr[7:0] == 8'hF0) ? 2'b10 : 2'b00;
        aw_p <= 1'b0;  w_p <= 1'b0;
      end
      if (M_bvalid && M_bready) M_bvalid <= 1'b0;
      if (M_arvalid && M_arready) begin
        M_rvalid <= 1'b1;
        M_rdata <= smem[M_araddr[9:2]];
        M_rresp <= (M_araddr[7:0] == 8'hF0) ? 2'b10 : 2'b00;
      end
      if (M_rvalid && M_rready) M_rvalid <= 1'b0;
    end
  end

  logic [1:0] wlog[$], rlog[$];
  logic [1:0] wprev, rprev;
  always @(negedge clk) begin
    if (wr_grant != 2'b00 && wprev == 2'b00) wlog.push_back(wr_grant);
    if (rd_grant != 2'b00 && rprev == 2'b00) rlog.push_back(rd_grant);
    wprev <= wr_grant;
    rprev <= rd_grant;
  end

  int n_chk = 0, n_fail = 0;
  logic [31:0] ref_mem [256];
  logic [1:0]  q_b0[$], q_b1[$];
  logic [31:0] q_r0[$], q_r1[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic ref_clear();
    for (int i = 0; i < 256; i++) ref_mem[i] = '0;
  endtask

  task automatic do_write(input int m, input logic [31:0] a, input logic [31:0] d,
                          input logic [3:0] st, input int bdelay, input logic [1:0] exp_resp);
    int n = 0, stall = 0;
    logic awh, wh, got = 1'b0;
    logic [1:0] resp = 2'b00, e;
    if (m == 0) q_b0.push_back(exp_resp); else q_b1.push_back(exp_resp);
    for (int b = 0; b < 4; b++) if (st[b]) ref_mem[a[9:2]][8*b +: 8] = d[8*b +: 8];
    @(posedge clk); #1;
    s_awaddr[m] = a;  s_awprot[m] = 3'(m + 1);  s_wdata[m] = d;  s_wstrb[m] = st;
    s_awvalid[m] = 1'b1;  s_wvalid[m] = 1'b1;  s_bready[m] = 1'b0;
    while ((s_awvalid[m] || s_wvalid[m]) && n < 40) begin
      awh = s_awvalid[m] && s_awready[m];
      wh  = s_wvalid[m] && s_wready[m];
      @(posedge clk); #1;
      if (awh) s_awvalid[m] = 1'b0;
      if (wh)  s_wvalid[m]  = 1'b0;
      n++;
    end
    while (!got && n < 80) begin
      if (s_bvalid[m]) begin
        if (stall >= bdelay) begin s_bready[m] = 1'b1; resp = s_bresp[m]; got = 1'b1; end
        else stall++;
      end
      @(posedge clk); #1;
      n++;
    end
    s_bready[m] = 1'b0;  s_awvalid[m] = 1'b0;  s_wvalid[m] = 1'b0;
    chk($sformatf("wr%0d_done_%0h", m, a), 64'(got), 64'd1);
    if (m == 0) e = q_b0.pop_front(); else e = q_b1.pop_front();
    chk($sformatf("wr%0d_bresp_%0h", m, a), 64'(resp), 64'(e));
  endtask

  task automatic do_read(input int m, input logic [31:0] a, input int rdelay,
                         input logic use_sb, output logic [31:0] data);
    int n = 0, stall = 0;
    logic arh, got = 1'b0;
    logic [1:0] resp = 2'b00;
    logic [31:0] e;
    data = '0;
    if (use_sb) begin
      if (m == 0) q_r0.push_back(ref_mem[a[9:2]]); else q_r1.push_back(ref_mem[a[9:2]]);
    end
    @(posedge clk); #1;
    s_araddr[m] = a;  s_arprot[m] = 3'(m + 4);  s_arvalid[m] = 1'b1;  s_rready[m] = 1'b0;
    while (s_arvalid[m] && n < 40) begin
      arh = s_arready[m];
      @(posedge clk); #1;
      if (arh) s_arvalid[m] = 1'b0;
      n++;
    end
    while (!got && n < 80) begin
      if (s_rvalid[m]) begin
        if (stall >= rdelay) begin
          s_rready[m] = 1'b1; data = s_rdata[m]; resp = s_rresp[m]; got = 1'b1;
        end else stall++;
      end
      @(posedge clk); #1;
      n++;
    end
    s_rready[m] = 1'b0;  s_arvalid[m] = 1'b0;
    chk($sformatf("rd%0d_done_%0h", m, a), 64'(got), 64'd1);
    chk($sformatf("rd%0d_rresp_%0h", m, a), 64'(resp), 64'd0);
    if (use_sb) begin
      if (m == 0) e = q_r0.pop_front(); else e = q_r1.pop_front();
      chk($sformatf("rd%0d_rdata_%0h", m, a), 64'(data), 64'(e));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd0, rd1;
    int k;
    for (int m = 0; m < 2; m++) begin
      s_awaddr[m] = '0; s_awprot[m] = '0; s_awvalid[m] = 1'b0; s_wdata[m] = '0;
      s_wstrb[m] = '0; s_wvalid[m] = 1'b0; s_bready[m] = 1'b0; s_araddr[m] = '0;
      s_arprot[m] = '0; s_arvalid[m] = 1'b0; s_rready[m] = 1'b0;
    end
    ref_clear();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    // Reset state
    chk("rst_wr_grant", 64'(wr_grant), 64'd0);
    chk("rst_rd_grant", 64'(rd_grant), 64'd0);
    chk("rst_M_awvalid", 64'(M_awvalid), 64'd0);
    chk("rst_M_arvalid", 64'(M_arvalid), 64'd0);
    chk("rst_S0_awready", 64'(s_awready[0]), 64'd0);
    chk("rst_S0_bvalid", 64'(s_bvalid[0]), 64'd0);
    chk("rst_S1_rdata", 64'(s_rdata[1]), 64'd0);
    rst = 1'b0;

    // Single S0 write, then read back
    fork
      do_write(0, 32'h10, 32'hDEADBEEF, 4'hF, 0, 2'b00);
      begin
        @(posedge clk); @(posedge clk); #2;
        chk("t1_wr_grant", 64'(wr_grant), 64'h1);
        chk("t1_M_awaddr", 64'(M_awaddr), 64'h10);
        chk("t1_M_awprot", 64'(M_awprot), 64'h1);
        chk("t1_M_wdata", 64'(M_wdata), 64'hDEADBEEF);
        chk("t1_M_awvalid", 64'(M_awvalid), 64'h1);
        chk("t1_S0_awready", 64'(s_awready[0]), 64'h1);
        chk("t1_S1_awready", 64'(s_awready[1]), 64'h0);
        chk("t1_S1_wready", 64'(s_wready[1]), 64'h0);
      end
    join
    do_read(0, 32'h10, 0, 1'b1, rd0);

    // Tie after reset: S0 first, then strict alternation
    rst = 1'b1; ref_clear();
    @(posedge clk); #1; rst = 1'b0;
    wlog.delete();
    fork
      begin
        do_write(0, 32'h30, 32'h00000030, 4'hF, 0, 2'b00);
        do_write(0, 32'h34, 32'h00000034, 4'hF, 0, 2'b00);
      end
      begin
        do_write(1, 32'h38, 32'h00000038, 4'hF, 0, 2'b00);
        do_write(1, 32'h3C, 32'h0000003C, 4'hF, 0, 2'b00);
      end
    join
    chk("t2_nwgrants", 64'(wlog.size()), 64'd4);
    if (wlog.size() >= 4) begin
      chk("t2_grant0", 64'(wlog[0]), 64'h1);
      chk("t2_grant1", 64'(wlog[1]), 64'h2);
      chk("t2_grant2", 64'(wlog[2]), 64'h1);
      chk("t2_grant3", 64'(wlog[3]), 64'h2);
    end
    do_read(0, 32'h34, 0, 1'b1, rd0);
    do_read(0, 32'h3C, 0, 1'b1, rd0);

    // Concurrent S0 write and S1 read of the same address
    fork
      do_write(0, 32'h10, 32'h12345678, 4'hF, 0, 2'b00);
      do_read(1, 32'h10, 0, 1'b0, rd1);
      begin
        @(posedge clk); @(posedge clk); #2;
        chk("t3_wr_grant", 64'(wr_grant), 64'h1);
        chk("t3_rd_grant", 64'(rd_grant), 64'h2);
      end
    join
    chk("t3_rdata_old_or_new", 64'(rd1 == 32'h0 || rd1 == 32'h12345678), 64'd1);

    // S0 holds bready low for 5 cycles while S1 waits; S1 gets SLVERR
    fork
      do_write(0, 32'h40, 32'h11112222, 4'hF, 5, 2'b00);
      begin
        @(posedge clk);
        do_write(1, 32'hF0, 32'h33334444, 4'hF, 0, 2'b10);
      end
      begin
        k = 0;
        while (!s_bvalid[0] && k < 20) begin @(posedge clk); #2; k++; end
        chk("t4_bvalid_seen", 64'(s_bvalid[0]), 64'd1);
        for (int i = 0; i < 4; i++) begin
          chk("t4_wr_grant", 64'(wr_grant), 64'h1);
          chk("t4_M_bvalid", 64'(M_bvalid), 64'h1);
          chk("t4_S1_awready", 64'(s_awready[1]), 64'h0);
          @(posedge clk); #2;
        end
      end
    join

    // Both masters read with rready held low 3 cycles
    do_write(0, 32'h20, 32'hA5A50001, 4'hF, 0, 2'b00);
    do_write(0, 32'h24, 32'hCAFEBEEF, 4'b0011, 0, 2'b00);
    rlog.delete();
    fork
      do_read(0, 32'h20, 3, 1'b1, rd0);
      do_read(1, 32'h24, 3, 1'b1, rd1);
      begin
        k = 0;
        while (!s_rvalid[0] && k < 20) begin @(posedge clk); #2; k++; end
        chk("t5_rvalid_seen", 64'(s_rvalid[0]), 64'd1);
        for (int i = 0; i < 3; i++) begin
          chk("t5_rd_grant", 64'(rd_grant), 64'h1);
          chk("t5_S1_arready", 64'(s_arready[1]), 64'h0);
          @(posedge clk); #2;
        end
      end
    join
    chk("t5_nrgrants", 64'(rlog.size()), 64'd2);
    if (rlog.size() >= 2) begin
      chk("t5_rgrant0", 64'(rlog[0]), 64'h1);
      chk("t5_rgrant1", 64'(rlog[1]), 64'h2);
    end

    // Reset with write in W_FWD and read in R_DATA
    @(posedge clk); #1;
    s_araddr[1] = 32'h30; s_arprot[1] = 3'd2; s_arvalid[1] = 1'b1; s_rready[1] = 1'b0;
    @(posedge clk); #1;
    s_awaddr[0] = 32'h50; s_wdata[0] = 32'h55; s_wstrb[0] = 4'hF;
    s_awvalid[0] = 1'b1; s_wvalid[0] = 1'b1; s_bready[0] = 1'b0;
    @(posedge clk); #1;
    s_arvalid[1] = 1'b0;
    chk("t6_pre_wr_grant", 64'(wr_grant), 64'h1);
    chk("t6_pre_rd_grant", 64'(rd_grant), 64'h2);
    chk("t6_pre_S1_rvalid", 64'(s_rvalid[1]), 64'h1);
    rst = 1'b1; s_awvalid[0] = 1'b0; s_wvalid[0] = 1'b0;
    ref_clear();
    @(posedge clk); #1;
    chk("t6_wr_grant", 64'(wr_grant), 64'h0);
    chk("t6_rd_grant", 64'(rd_grant), 64'h0);
    chk("t6_M_awvalid", 64'(M_awvalid), 64'h0);
    chk("t6_M_wvalid", 64'(M_wvalid), 64'h0);
    chk("t6_M_arvalid", 64'(M_arvalid), 64'h0);
    chk("t6_M_rready", 64'(M_rready), 64'h0);
    chk("t6_S1_rvalid", 64'(s_rvalid[1]), 64'h0);
    chk("t6_S0_awready", 64'(s_awready[0]), 64'h0);
    rst = 1'b0;
    wlog.delete();
    fork
      do_write(0, 32'h60, 32'h00000060, 4'hF, 0, 2'b00);
      do_write(1, 32'h64, 32'h00000064, 4'hF, 0, 2'b00);
    join
    chk("t6_nwgrants", 64'(wlog.size()), 64'd2);
    if (wlog.size() >= 2) begin
      chk("t6_grant0", 64'(wlog[0]), 64'h1);
      chk("t6_grant1", 64'(wlog[1]), 64'h2);
    end
    do_read(1, 32'h60, 0, 1'b1, rd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
